// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback trace buffer.
//   trace_state_e : capture FSM encoding, visible on the 'state' status output
//   *_lsb helpers : bit offsets of the fields inside a stored entry,
//                   laid out as {reg, data, pc} with pc in the low bits
package wb_trace_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } trace_state_e;

    localparam int unsigned PcLsb = 0;

    function automatic int unsigned data_lsb(input int unsigned pc_w);
        return pc_w;
    endfunction

    function automatic int unsigned reg_lsb(input int unsigned pc_w, input int unsigned data_w);
        return pc_w + data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous (zero-latency) read port. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module trace_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 45
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback-stage trace buffer. Captures register writebacks into a circular
// buffer, optionally stops a programmable number of entries after a trigger
// register is written, then lets a consumer drain entries oldest first.
//   SYS_clk, SYS_reset             : clock, synchronous active-low reset
//   arm                            : clear/start pulse (also stops free-run capture)
//   trig_en, trig_reg, post_count  : trigger setup
//   WB_RegWrite_signal, WB_write_register, WB_write_data, PC : writeback tap
//   rd_ready / rd_valid, rd_reg, rd_data, rd_pc : oldest-entry readout
//   state, count, triggered, overflow : status
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     SYS_clk,
    input  logic                     SYS_reset,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [REG_W-1:0]         trig_reg,
    input  logic [$clog2(DEPTH):0]   post_count,
    input  logic                     WB_RegWrite_signal,
    input  logic [REG_W-1:0]         WB_write_register,
    input  logic [DATA_W-1:0]        WB_write_data,
    input  logic [PC_W-1:0]          PC,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [REG_W-1:0]         rd_reg,
    output logic [DATA_W-1:0]        rd_data,
    output logic [PC_W-1:0]          rd_pc,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     triggered,
    output logic                     overflow
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ENTRY_W  = REG_W + DATA_W + PC_W;
    localparam int unsigned DATA_LSB = data_lsb(PC_W);
    localparam int unsigned REG_LSB  = reg_lsb(PC_W, DATA_W);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    trace_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, post_cnt_q, post_cnt_d;
    logic             triggered_q, triggered_d, overflow_q, overflow_d;
    logic             cap_ev, cap_we, trig_hit, rd_fire;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    assign cap_ev   = WB_RegWrite_signal && (WB_write_register != '0) &&
                      ((state_q == StArmed) || (state_q == StPost));
    assign trig_hit = trig_en && (WB_write_register == trig_reg);
    assign rd_valid = (state_q == StDone) && (count_q != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_entry = {WB_write_register, WB_write_data, PC};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        cap_we      = 1'b0;

        case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                // An arm pulse suppresses capture this cycle; it only stops a
                // free-running (untriggered) capture.
                if (arm) begin
                    if (!trig_en) state_d = StDone;
                end else if (cap_ev) begin
                    cap_we = 1'b1;
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        post_cnt_d  = post_count;
                        state_d     = (post_count == '0) ? StDone : StPost;
                    end
                end
            end
            StPost: begin
                if (cap_ev) begin
                    cap_we     = 1'b1;
                    post_cnt_d = post_cnt_q - CNT_W'(1);
                    if (post_cnt_q <= CNT_W'(1)) state_d = StDone;
                end
            end
            StDone: begin
                if (arm) begin
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                    overflow_d  = 1'b0;
                    triggered_d = 1'b0;
                    state_d     = StArmed;
                end else if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Captures never happen in StDone, so this cannot collide with a read.
        if (cap_we) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q == FULL) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk_i   (SYS_clk),
        .we_i    (cap_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign rd_reg    = rd_entry[REG_LSB +: REG_W];
    assign rd_data   = rd_entry[DATA_LSB +: DATA_W];
    assign rd_pc     = rd_entry[PcLsb +: PC_W];
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;

endmodule
